// File: rtl/my_alu_pkg.sv
// -----------------------------------------------------------------------------
// my_alu_pkg
// Shared definitions for the my_alu registered arithmetic unit.
//   MY_ALU_WIDTH : default operand/result width.
//   alu_op_t     : 2-bit opcode encoding (OFF, ADD, SUB, NOP).
// -----------------------------------------------------------------------------
package my_alu_pkg;

   localparam int unsigned MY_ALU_WIDTH = 4;

   typedef enum logic [1:0] {
      OP_OFF = 2'b00,
      OP_ADD = 2'b01,
      OP_SUB = 2'b10,
      OP_NOP = 2'b11
   } alu_op_t;

endpackage

// File: rtl/my_alu_addsub.sv
// -----------------------------------------------------------------------------
// my_alu_addsub
// Combinational WIDTH-bit adder/subtractor built around a single adder.
// Ports:
//   A, B        : unsigned operands
//   sub         : 0 = A+B, 1 = A-B
//   result      : low WIDTH bits of the sum/difference (wraps)
//   cout_borrow : carry-out for add, borrow (A<B) for subtract
// -----------------------------------------------------------------------------
module my_alu_addsub
   import my_alu_pkg::*;
#(
   parameter int unsigned WIDTH = MY_ALU_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   output logic [WIDTH-1:0] result,
   output logic             cout_borrow
);

   logic [WIDTH-1:0] w_b_op;
   logic [WIDTH:0]   w_sum;

   // Subtract as A + ~B + 1; the +1 comes in as a carry-in equal to sub.
   assign w_b_op = sub ? ~B : B;
   assign w_sum  = {1'b0, A} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, sub};

   assign result = w_sum[WIDTH-1:0];

   // In the A + ~B + 1 form a carry-out means "no borrow", so invert it.
   assign cout_borrow = sub ? ~w_sum[WIDTH] : w_sum[WIDTH];

endmodule

// File: rtl/my_alu.sv
// -----------------------------------------------------------------------------
// my_alu
// Registered 4-bit (by default) arithmetic unit: each rising clk edge captures
// OFF / ADD / SUB / NOP of the current operands; results appear one edge later.
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous active-low reset (0 = reset)
//   A, B   : unsigned operands
//   alu_op : 00 OFF, 01 ADD, 10 SUB, 11 NOP
//   out    : registered result
//   flag   : registered carry (ADD) / borrow (SUB)
//   zero   : registered "out == 0" (only when MY_ALU_ZERO_FLAG_EN is defined)
// Interface: no handshake. A new operation is taken on every rising edge and
// its result is visible on out/flag right after that edge; NOP leaves the
// registers untouched.
// -----------------------------------------------------------------------------
module my_alu
   import my_alu_pkg::*;
#(
   parameter int unsigned WIDTH = MY_ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       alu_op,
   output logic [WIDTH-1:0] out,
   output logic             flag
`ifdef MY_ALU_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   alu_op_t          w_op;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_we;
   logic [WIDTH-1:0] w_out_d;
   logic             w_flag_d;

   logic [WIDTH-1:0] r_out;
   logic             r_flag;

   assign w_op = alu_op_t'(alu_op);

   my_alu_addsub #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .A           (A),
      .B           (B),
      .sub         (w_op == OP_SUB),
      .result      (w_sum),
      .cout_borrow (w_cout)
   );

   // Opcode decode: OFF writes zeros, ADD/SUB write the adder result,
   // NOP suppresses the write so the registers hold.
   always_comb begin
      w_we     = 1'b1;
      w_out_d  = '0;
      w_flag_d = 1'b0;
      case (w_op)
         OP_OFF: begin
            w_out_d  = '0;
            w_flag_d = 1'b0;
         end
         OP_ADD, OP_SUB: begin
            w_out_d  = w_sum;
            w_flag_d = w_cout;
         end
         OP_NOP: begin
            w_we = 1'b0;
         end
         default: begin
            w_we = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out  <= '0;
         r_flag <= 1'b0;
      end else if (w_we) begin
         r_out  <= w_out_d;
         r_flag <= w_flag_d;
      end
   end

   assign out  = r_out;
   assign flag = r_flag;

`ifdef MY_ALU_ZERO_FLAG_EN
   logic r_zero;

   // Reset to 1 so zero agrees with the cleared out value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_zero <= 1'b1;
      end else if (w_we) begin
         r_zero <= (w_out_d == '0);
      end
   end

   assign zero = r_zero;
`endif

endmodule

// File: tb/tb_my_alu.sv
// -----------------------------------------------------------------------------
// tb_my_alu
// Directed-vector bench for my_alu. The driver applies operands on the falling
// edge and pushes the hand-computed response into exp_q; the monitor pops one
// entry just after each rising edge and compares it with out/flag (and zero
// when MY_ALU_ZERO_FLAG_EN is defined). Asynchronous-reset behaviour is checked
// directly by the driver, since it does not follow the clock.
// -----------------------------------------------------------------------------
module tb_my_alu;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [1:0]   alu_op;
   logic [W-1:0] out;
   logic         flag;
`ifdef MY_ALU_ZERO_FLAG_EN
   logic         zero;
`endif

   // Expected entry: {zero, flag, out}
   logic [W+1:0] exp_q[$];
   int           n_checks;
   int           n_pass;

   my_alu #(
      .WIDTH (W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .B      (B),
      .alu_op (alu_op),
      .out    (out),
      .flag   (flag)
`ifdef MY_ALU_ZERO_FLAG_EN
      ,
      .zero   (zero)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- comparison ----------------
   task automatic check(input string name, input logic [W-1:0] e_out,
                        input logic e_flag, input logic e_zero);
      logic ok;
      ok = (out === e_out) && (flag === e_flag);
`ifdef MY_ALU_ZERO_FLAG_EN
      ok = ok && (zero === e_zero);
      if (!ok)
         $display("FAIL %s: got out=%h flag=%b zero=%b, expected out=%h flag=%b zero=%b",
                  name, out, flag, zero, e_out, e_flag, e_zero);
`else
      if (!ok)
         $display("FAIL %s: got out=%h flag=%b, expected out=%h flag=%b (zero n/a %b)",
                  name, out, flag, e_out, e_flag, e_zero);
`endif
      n_checks++;
      if (ok) n_pass++;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) begin
      logic [W+1:0] e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("result", e[W-1:0], e[W], e[W+1]);
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic [W-1:0] e_out,
                        input logic e_flag);
      @(negedge clk);
      A      = a;
      B      = b;
      alu_op = op;
      exp_q.push_back({(e_out == '0), e_flag, e_out});
   endtask

   task automatic wait_drain();
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #2;
      if (exp_q.size() != 0) begin
         $display("FAIL drain: %0d expected results never compared, required 0",
                  exp_q.size());
         n_checks++;
      end
   endtask

   // Directed vectors: A, B, op, expected out, expected flag
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
      logic [W-1:0] e_out;
      logic         e_flag;
   } vec_t;

   vec_t vecs[$];

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b0;
      A        = '0;
      B        = '0;
      alu_op   = 2'b00;

      // Reset state
      #1;
      check("reset_init", 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;

      // Load out=5, then assert reset between edges
      drive(4'h2, 4'h3, 2'b01, 4'h5, 1'b0);
      wait_drain();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset", 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      drive(4'h3, 4'h4, 2'b01, 4'h7, 1'b0);

      // ADD carry, SUB borrow, NOP hold, OFF, back-to-back op changes
      vecs = '{
         '{4'h9, 4'h8, 2'b01, 4'h1, 1'b1},
         '{4'hF, 4'h1, 2'b01, 4'h0, 1'b1},
         '{4'h2, 4'h3, 2'b01, 4'h5, 1'b0},
         '{4'h7, 4'h2, 2'b10, 4'h5, 1'b0},
         '{4'h2, 4'h7, 2'b10, 4'hB, 1'b1},
         '{4'h6, 4'h6, 2'b10, 4'h0, 1'b0},
         '{4'h5, 4'h7, 2'b01, 4'hC, 1'b0},
         '{4'hF, 4'hF, 2'b11, 4'hC, 1'b0},
         '{4'hF, 4'hF, 2'b11, 4'hC, 1'b0},
         '{4'hF, 4'hF, 2'b11, 4'hC, 1'b0},
         '{4'hF, 4'hF, 2'b00, 4'h0, 1'b0},
         '{4'h5, 4'h6, 2'b01, 4'hB, 1'b0},
         '{4'h3, 4'h5, 2'b10, 4'hE, 1'b1},
         '{4'h9, 4'h9, 2'b00, 4'h0, 1'b0},
         '{4'h8, 4'h8, 2'b01, 4'h0, 1'b1},
         '{4'h4, 4'h4, 2'b10, 4'h0, 1'b0},
         '{4'h1, 4'h1, 2'b01, 4'h2, 1'b0}
      };
      foreach (vecs[i])
         drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].e_out, vecs[i].e_flag);
      wait_drain();

      // Mid-operation reset: pending ADD is discarded
      @(negedge clk);
      A      = 4'h1;
      B      = 4'h2;
      alu_op = 2'b01;
      #2;
      rst = 1'b0;
      #1;
      check("midop_reset_now", 4'h0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("midop_reset_held", 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("release_no_edge", 4'h0, 1'b0, 1'b1);
      drive(4'h1, 4'h2, 2'b01, 4'h3, 1'b0);
      drive(4'hA, 4'h7, 2'b01, 4'h1, 1'b1);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

// File: doc/my_alu.md
Name: my_alu

Overview:
- Small registered 4-bit arithmetic unit for mini-project datapaths.
- On each rising clock edge it captures one of four results selected by a 2-bit opcode: off, add, subtract, or hold.
- It drives a result and a carry/borrow flag.
- Outputs are registered, so a result appears one clock after its operands and opcode are applied.

Parameters:
- WIDTH, 4, operand and result width in bits. Must be ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset. 0 = reset asserted.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- alu_op  input  2  opcode: 00 OFF, 01 ADD, 10 SUB, 11 NOP.
- out  output  WIDTH  registered result.
- flag  output  1  registered carry (ADD) or borrow (SUB).

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-low.
- Reset:
  - When rst falls, out=0 and flag=0 immediately, independent of clk.
  - Both stay 0 while rst=0.
  - Reset may assert mid-operation. Any pending result is discarded.
- Release: after rst returns to 1, the first rising clk edge performs the selected operation.
- Latency: operands and alu_op sampled at rising edge N appear on out/flag after edge N. Latency is exactly 1 cycle, with no pipeline stages beyond this. A new operation is accepted every cycle; there is no handshake.
- OFF (00): out←0, flag←0.
- ADD (01):
  - Form a (WIDTH+1)-bit sum {flag,out} ← A+B.
  - out is the low WIDTH bits and wraps modulo 2^WIDTH. flag is the carry-out.
- SUB (10):
  - out ← (A−B) mod 2^WIDTH, two's complement wrap.
  - flag ← 1 iff A<B (borrow). A=B gives out=0, flag=0.
- NOP (11): out and flag hold their previous values. Registers are not written.
- Inputs are unsigned. No overflow detection beyond carry/borrow.
- Unknown (X) inputs: no functional requirement. Outputs may go X. Reset must still clear them.
- Outputs change only on a rising clk edge or on rst assertion.

Optional Feature:
- Macro MY_ALU_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit, registered).
  - zero is written on the same edges as out and is 1 iff the newly written out equals 0.
  - zero holds on NOP.
  - Reset value is 1, consistent with out=0.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package my_alu_pkg holds:
  - typedef enum logic[1:0] alu_op_t {OP_OFF=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_NOP=2'b11}.
  - A localparam for the default width of 4.
- One natural sub-module, my_alu_addsub: combinational WIDTH-bit adder/subtractor.
  - Inputs: A, B, sub.
  - Outputs: result[WIDTH-1:0] and cout_borrow.
  - SUB is formed as A + ~B + 1, and borrow = ~carry.
- The top level holds the opcode decode and the output registers.

Test Plan:
- Reset: rst=0 asynchronously with clk idle, out=5 beforehand -> out=0, flag=0 immediately. Release rst, apply A=3,B=4,op=01 -> after next edge out=7, flag=0.
- ADD carry: A=9,B=8,op=01 -> out=1, flag=1. A=F,B=1 -> out=0, flag=1. A=2,B=3 -> out=5, flag=0.
- SUB borrow: A=7,B=2,op=10 -> out=5, flag=0. A=2,B=7 -> out=B (hex), flag=1. A=6,B=6 -> out=0, flag=0.
- OFF/NOP: after ADD producing out=C, flag=0, apply op=11 with A=F,B=F for 3 cycles -> out stays C, flag stays 0. Then op=00 -> out=0, flag=0.
- Back-to-back and mid-op reset: change op every cycle ADD→SUB→OFF→ADD. Each result appears exactly one edge later. Assert rst between edges -> outputs clear at once, and the next result appears only after rst deasserts.
- With MY_ALU_ZERO_FLAG_EN: SUB A=4,B=4 -> zero=1. ADD A=1,B=1 -> zero=0. Reset -> zero=1.
